run_timer_pr: RTL and testbench

- Survival-time and personal-record (PR) tracker placed between the game logic (block_controller, which drives deadFlag) and the 7-segment scanner.
- Counts elapsed run time in BCD as SS.cc (seconds and centiseconds).
- Freezes the count when the player dies and latches a new PR when the run beats it.
- Runs on the 100 MHz system clock and synchronises the dead level internally, because deadFlag is produced in the divided move_clk domain.

---
 rtl/run_timer_pr.sv | 125 ++++++++++++
 tb/tb_run_timer_pr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_timer_pr.sv
// Survival-time and personal-record tracker.
// Counts SS.cc in BCD, freezes on death, latches a new PR.
`timescale 1ns/1ps
module run_timer_pr #(
  parameter int TICK_DIV    = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dead,
  input  logic        clr_pr,
  output logic [15:0] run_bcd,
  output logic [15:0] pr_bcd,
  output logic        pr_valid,
  output logic        running,
  output logic        new_pr,
  output logic        saturated
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DEAD    = 2'd1,
    RESTART = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic          dead_s;
  logic          dead_q;
  logic          rise;
  logic          fall;
  logic          tick;
  logic          judge;
  logic          at_max;
  logic [PW-1:0] presc;
  logic [15:0]   run_inc;

  assign dead_s = sync[SYNC_STAGES-1];
  assign rise   = dead_s & ~dead_q;
  assign fall   = ~dead_s & dead_q;
  assign tick   = (state == RUN) && (presc == TOP);
  assign at_max = (run_bcd == 16'h9999);

  // Ripple BCD increment; never reached at 99.99
  always_comb begin
    run_inc = run_bcd;
    if (run_bcd[3:0] != 4'd9) begin
      run_inc[3:0] = run_bcd[3:0] + 4'd1;
    end else begin
      run_inc[3:0] = 4'd0;
      if (run_bcd[7:4] != 4'd9) begin
        run_inc[7:4] = run_bcd[7:4] + 4'd1;
      end else begin
        run_inc[7:4] = 4'd0;
        if (run_bcd[11:8] != 4'd9) begin
          run_inc[11:8] = run_bcd[11:8] + 4'd1;
        end else begin
          run_inc[11:8]  = 4'd0;
          run_inc[15:12] = run_bcd[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (rise) state_nx = DEAD;
      DEAD:    if (fall) state_nx = RESTART;
      RESTART: state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      sync      <= '0;
      dead_q    <= 1'b0;
      presc     <= '0;
      run_bcd   <= '0;
      running   <= 1'b1;
      new_pr    <= 1'b0;
      saturated <= 1'b0;
      judge     <= 1'b0;
      if (clr_pr) begin
        pr_bcd   <= '0;
        pr_valid <= 1'b0;
      end
    end else begin
      state   <= state_nx;
      sync    <= {sync[SYNC_STAGES-2:0], dead};
      dead_q  <= dead_s;
      running <= (state_nx == RUN);
      new_pr  <= 1'b0;
      judge   <= (state == RUN) && rise;
      // PR decision on the first DEAD cycle
      if (judge && (!pr_valid || run_bcd > pr_bcd)) begin
        pr_bcd   <= run_bcd;
        pr_valid <= 1'b1;
        new_pr   <= 1'b1;
      end
      unique case (state)
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick && !rise && !at_max) begin
            run_bcd <= run_inc;
            if (run_inc == 16'h9999) saturated <= 1'b1;
          end
        end
        RESTART: begin
          presc     <= '0;
          run_bcd   <= '0;
          saturated <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_timer_pr.sv
// Scoreboard bench for run_timer_pr.
// Stimulus queues expectations; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_run_timer_pr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1, dead4 = 1'b0, clr4 = 1'b1;
  logic [15:0] run4, pr4;
  logic        val4, rn4, np4, sat4;
  logic        rst2 = 1'b1, dead2 = 1'b0, clr2 = 1'b1;
  logic [15:0] run2, pr2;
  logic        val2, rn2, np2, sat2;

  run_timer_pr #(.TICK_DIV(4), .SYNC_STAGES(2)) u4 (
    .clk(clk), .rst(rst4), .dead(dead4), .clr_pr(clr4),
    .run_bcd(run4), .pr_bcd(pr4), .pr_valid(val4),
    .running(rn4), .new_pr(np4), .saturated(sat4)
  );

  run_timer_pr #(.TICK_DIV(2), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst2), .dead(dead2), .clr_pr(clr2),
    .run_bcd(run2), .pr_bcd(pr2), .pr_valid(val2),
    .running(rn2), .new_pr(np2), .saturated(sat2)
  );

  typedef struct {
    bit          sel;
    string       name;
    bit          chk_run;
    logic [15:0] run;
    logic [15:0] pr;
    logic        valid;
    logic        running;
    logic        sat;
    logic        newpr;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] pr_q[$];
  logic [15:0] frz_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          pulse_mode = 1'b0;
  bit          prev_np = 1'b0;
  bit          prev_rn = 1'b0;
  logic [15:0] exp_pr = '0;
  logic        exp_valid = 1'b0;

  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10),
            4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic snap(input bit sel, input string name,
                      input bit chk_run, input logic [15:0] run,
                      input logic [15:0] pr, input logic valid,
                      input logic running, input logic sat,
                      input logic newpr);
    snap_t s;
    s.sel = sel; s.name = name; s.chk_run = chk_run;
    s.run = run; s.pr = pr; s.valid = valid;
    s.running = running; s.sat = sat; s.newpr = newpr;
    snap_q.push_back(s);
  endtask

  // Monitor: snapshots, new_pr pulses and freeze events
  always @(negedge clk) begin
    snap_t       s;
    logic [35:0] act;
    logic [35:0] req;
    logic [15:0] e;
    if (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      if (s.sel) act = {run2, pr2, val2, rn2, sat2, np2};
      else       act = {run4, pr4, val4, rn4, sat4, np4};
      req = {s.run, s.pr, s.valid, s.running, s.sat, s.newpr};
      if (!s.chk_run) begin
        act[35:20] = '0;
        req[35:20] = '0;
      end
      tests++;
      if (act !== req) begin
        fails++;
        $display("FAIL %s: got run=%h pr=%h v=%b run=%b sat=%b np=%b, want run=%h pr=%h v=%b run=%b sat=%b np=%b",
                 s.name, act[35:20], act[19:4], act[3], act[2],
                 act[1], act[0], req[35:20], req[19:4], req[3],
                 req[2], req[1], req[0]);
      end
    end
    if (np4) begin
      tests++;
      if (prev_np) begin
        fails++;
        $display("FAIL new_pr_width: got 2+ cycles high, want 1");
      end
      if (pr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL new_pr_unexpected: got pulse pr=%h, want none", pr4);
      end else begin
        e = pr_q.pop_front();
        tests++;
        if ({val4, pr4} !== {1'b1, e}) begin
          fails++;
          $display("FAIL new_pr_value: got v=%b pr=%h, want v=1 pr=%h",
                   val4, pr4, e);
        end
      end
    end
    prev_np = np4;
    if (prev_rn && !rn4) begin
      if (frz_q.size() != 0) begin
        e = frz_q.pop_front();
        tests++;
        if (run4 !== e) begin
          fails++;
          $display("FAIL freeze_value: got run=%h, want %h", run4, e);
        end
      end else if (!pulse_mode) begin
        tests++; fails++;
        $display("FAIL freeze_unexpected: got stop at run=%h, want none", run4);
      end
    end
    prev_rn = rn4;
  end

  task automatic wait_running();
    int k = 0;
    while (!rn4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rn4) begin
      tests++; fails++;
      $display("FAIL wait_running: got running=%b after 50 cycles, want 1", rn4);
    end
  endtask

  // Die exactly when the count shows n; the next tick lands on the freeze edge
  task automatic die(input int n, input bit upd, input bit drop);
    wait_running();
    repeat (4 * n) @(posedge clk);
    #1;
    snap(0, "pre_death", 1, bcd(n), exp_pr, exp_valid, 1, 0, 0);
    frz_q.push_back(bcd(n));
    if (upd) begin
      exp_pr = bcd(n);
      exp_valid = 1'b1;
      pr_q.push_back(bcd(n));
    end
    dead4 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    snap(0, "after_death", 1, bcd(n), exp_pr, exp_valid, 0, 0, 0);
    if (drop) dead4 = 1'b0;
  endtask

  // One-period pulse that always straddles exactly one rising edge
  task automatic pulse();
    int ph = $urandom_range(1, 8);
    #(ph);
    dead4 = 1'b1;
    #10;
    dead4 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    snap(0, "pulse_recover", 0, '0, 16'h0011, 1, 1, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    clr4 = 1'b0;
    snap(0, "reset_state", 1, '0, '0, 0, 1, 0, 0);

    die(10, 1, 1);
    die(7, 0, 1);
    die(10, 0, 1);
    die(11, 1, 0);

    frz_q.push_back(16'h0000);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    snap(0, "rst_in_dead", 1, '0, 16'h0011, 1, 1, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    snap(0, "redeath_at_zero", 1, '0, 16'h0011, 1, 0, 0, 0);
    dead4 = 1'b0;
    wait_running();
    snap(0, "restart_zero", 1, '0, 16'h0011, 1, 1, 0, 0);

    pulse_mode = 1'b1;
    for (int i = 0; i < 4; i++) pulse();
    pulse_mode = 1'b0;

    rst4 = 1'b1;
    clr4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    clr4 = 1'b0;
    exp_pr = '0;
    exp_valid = 1'b0;
    snap(0, "rst_clr_pr", 1, '0, '0, 0, 1, 0, 0);

    @(posedge clk); #1;
    rst2 = 1'b0;
    clr2 = 1'b0;
    repeat (19997) @(posedge clk);
    #1;
    snap(1, "sat_minus1", 1, 16'h9998, '0, 0, 1, 0, 0);
    @(posedge clk); #1;
    snap(1, "sat_reach", 1, 16'h9999, '0, 0, 1, 1, 0);
    repeat (40) @(posedge clk);
    #1;
    snap(1, "sat_hold", 1, 16'h9999, '0, 0, 1, 1, 0);
    dead2 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    snap(1, "sat_death", 1, 16'h9999, 16'h9999, 1, 0, 1, 0);
    dead2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    snap(1, "sat_restart", 1, 16'h0002, 16'h9999, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    tests++;
    if (pr_q.size() != 0 || frz_q.size() != 0 || snap_q.size() != 0) begin
      fails++;
      $display("FAIL events_missing: got pr=%0d frz=%0d snap=%0d left, want 0",
               pr_q.size(), frz_q.size(), snap_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, want finish");
    $fatal(1);
  end

endmodule
